// File: rtl/button_irq_array.sv
// Multi-channel push-button interrupt source in an IEI/IEO daisy chain; optional debounce via BUTTON_DEBOUNCE_EN.
// Latency: in[i] rise to pending[i] is SYNC_STAGES+DEBOUNCE_CYCLES+1 cycles (SYNC_STAGES+1 without debounce).
// Backpressure: pending bits hold until a falling ack edge retires the highest-priority one; no input stalling.
module button_irq_array #(
  parameter int CHANNELS        = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  localparam int VW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] in,
  input  logic [CHANNELS-1:0] ie,
  input  logic                iei,
  input  logic                ack,
  output logic                ieo,
  output logic                irq,
  output logic [VW-1:0]       vector,
  output logic [CHANNELS-1:0] pending
);

  logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_q, sync_d;
  logic [CHANNELS-1:0] s, f, prev_q, prev_d, rise, set, clr, pending_q, pending_d;
  logic                ack_q, ack_d, ack_fall, any_pend;
  logic [VW-1:0]       sel;

  // Stage 0 takes the raw pin; the last stage is the synchronized level.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], in};
    s      = sync_q[SYNC_STAGES-1];
  end

`ifdef BUTTON_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [CHANNELS-1:0] filt_q, filt_d;
  logic [CW-1:0]       cnt_q [CHANNELS];
  logic [CW-1:0]       cnt_d [CHANNELS];

  always_comb begin
    filt_d = filt_q;
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_d[i] = '0;
      if (s[i] != filt_q[i]) begin
        if (cnt_q[i] == CNT_MAX) filt_d[i] = s[i];
        else                     cnt_d[i]  = cnt_q[i] + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      filt_q <= '0;
      for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= '0;
    end else begin
      filt_q <= filt_d;
      for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign f = filt_q;
`else
  assign f = s;
`endif

  always_comb begin
    prev_d   = f;
    rise     = f & ~prev_q;
    set      = rise & ie;
    any_pend = |pending_q;
    sel      = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (pending_q[i]) sel = VW'(i);
    end
    irq      = iei & any_pend;
    ieo      = iei & ~any_pend;
    ack_d    = ack;
    ack_fall = ack_q & ~ack;
    clr      = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      clr[i] = ack_fall & irq & (sel == VW'(i));
    end
    // A fresh edge beats a same-cycle acknowledge on that channel.
    pending_d = (pending_q & ~clr) | set;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= '0;
      prev_q    <= '0;
      pending_q <= '0;
      ack_q     <= 1'b1;
    end else begin
      sync_q    <= sync_d;
      prev_q    <= prev_d;
      pending_q <= pending_d;
      ack_q     <= ack_d;
    end
  end

  assign vector  = sel;
  assign pending = pending_q;

endmodule
